// File: rtl/motor_pkg.sv
// Shared motor-path definitions.
//   DIR_FWD / DIR_REV : direction encoding, also used by the H-bridge controller.
//   gray_e            : the 2-bit {A,B} quadrature states in forward order.
//   decode_t          : result of comparing two consecutive {A,B} samples.
//   quad_decode()     : (prev, cur) -> {step, up, err}.
package motor_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Forward rotation walks GRAY_0 -> GRAY_1 -> GRAY_2 -> GRAY_3 -> GRAY_0.
  typedef enum logic [1:0] {
    GRAY_0 = 2'b00,
    GRAY_1 = 2'b01,
    GRAY_2 = 2'b11,
    GRAY_3 = 2'b10
  } gray_e;

  typedef struct packed {
    logic step;  // a legal single-bit transition happened
    logic up;    // direction of that step (DIR_FWD / DIR_REV)
    logic err;   // both bits changed at once
  } decode_t;

  function automatic gray_e gray_next(input gray_e s);
    case (s)
      GRAY_0:  return GRAY_1;
      GRAY_1:  return GRAY_2;
      GRAY_2:  return GRAY_3;
      default: return GRAY_0;
    endcase
  endfunction

  function automatic decode_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    decode_t r;
    r = '0;
    if (cur == gray_next(gray_e'(prev))) begin
      r.step = 1'b1;
      r.up   = DIR_FWD;
    end else if (prev == gray_next(gray_e'(cur))) begin
      r.step = 1'b1;
      r.up   = DIR_REV;
    end else if ((prev ^ cur) == 2'b11) begin
      r.err = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Synchroniser plus glitch filter for one encoder channel.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   din  : raw asynchronous channel input
//   dout : filtered level; follows the synchronised level only after it has
//          differed from dout for FILTER_LEN consecutive clock edges.
module enc_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_q, sync_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    // Count consecutive edges where the synchronised level disagrees with
    // the accepted one; any agreeing edge restarts the count.
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The synchroniser keeps sampling through reset so that the filtered level
  // can be seeded with the live input level.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= sync_q[1];
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/quad_encoder_reader.sv
// Quadrature encoder reader: 4x decode of filtered A/B into position,
// direction, step error and per-window speed.
//   clk, rst    : clock and synchronous active-high reset
//   enc_a/enc_b : asynchronous encoder channels
//   clear_pos   : zero the position at the next edge
//   position    : signed step count, wraps modulo 2^POS_WIDTH
//   dir         : direction of the last valid step (DIR_FWD / DIR_REV)
//   speed       : |steps| in the last completed window, saturating
//   speed_valid : one-cycle pulse when speed is refreshed
//   step_err    : one-cycle pulse on a two-bit A/B transition
module quad_encoder_reader
  import motor_pkg::*;
#(
  parameter int POS_WIDTH     = 16,
  parameter int SPEED_WIDTH   = 12,
  parameter int WINDOW_CYCLES = 100000,
  parameter int FILTER_LEN    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enc_a,
  input  logic                   enc_b,
  input  logic                   clear_pos,
  output logic [POS_WIDTH-1:0]   position,
  output logic                   dir,
  output logic [SPEED_WIDTH-1:0] speed,
  output logic                   speed_valid,
  output logic                   step_err
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]       WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [SPEED_WIDTH-1:0] SPEED_MAX = '1;

  logic a_filt, b_filt;
  logic [1:0] ab_cur;

  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (enc_a),
    .dout (a_filt)
  );

  enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (enc_b),
    .dout (b_filt)
  );

  assign ab_cur = {a_filt, b_filt};

  logic [1:0]             ab_prev_q, ab_prev_d;
  logic                   armed_q, armed_d;
  logic [POS_WIDTH-1:0]   position_q, position_d;
  logic                   dir_q, dir_d;
  logic                   step_err_q, step_err_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [SPEED_WIDTH-1:0] acc_q, acc_d;
  logic [SPEED_WIDTH-1:0] speed_q, speed_d;
  logic                   speed_valid_q, speed_valid_d;
  decode_t                dec;
  logic                   win_wrap;

  always_comb begin
    // The filters reload at reset, so the first cycle afterwards compares
    // against a stale previous value; armed_q suppresses that one decode.
    dec           = armed_q ? quad_decode(ab_prev_q, ab_cur) : '0;
    ab_prev_d     = ab_cur;
    armed_d       = 1'b1;
    win_wrap      = (win_q == WIN_LAST);

    position_d    = position_q;
    if (clear_pos) begin
      position_d = '0;
    end else if (dec.step) begin
      position_d = (dec.up == DIR_FWD) ? position_q + 1'b1 : position_q - 1'b1;
    end

    dir_d         = dec.step ? dec.up : dir_q;
    step_err_d    = dec.err;

    win_d         = win_wrap ? '0 : win_q + 1'b1;
    speed_d       = speed_q;
    speed_valid_d = 1'b0;
    acc_d         = acc_q;
    if (win_wrap) begin
      // A step decoded in the wrap cycle belongs to the new window.
      speed_d       = acc_q;
      speed_valid_d = 1'b1;
      acc_d         = SPEED_WIDTH'(dec.step);
    end else if (dec.step && (acc_q != SPEED_MAX)) begin
      acc_d = acc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ab_prev_q     <= ab_cur;
      armed_q       <= 1'b0;
      position_q    <= '0;
      dir_q         <= 1'b0;
      step_err_q    <= 1'b0;
      win_q         <= '0;
      acc_q         <= '0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
    end else begin
      ab_prev_q     <= ab_prev_d;
      armed_q       <= armed_d;
      position_q    <= position_d;
      dir_q         <= dir_d;
      step_err_q    <= step_err_d;
      win_q         <= win_d;
      acc_q         <= acc_d;
      speed_q       <= speed_d;
      speed_valid_q <= speed_valid_d;
    end
  end

  assign position    = position_q;
  assign dir         = dir_q;
  assign step_err    = step_err_q;
  assign speed       = speed_q;
  assign speed_valid = speed_valid_q;

endmodule

// File: tb/tb_quad_encoder_reader.sv
module tb_quad_encoder_reader;

  localparam int F  = 3;
  localparam int W  = 100;
  localparam int PW = 16;
  localparam int SW = 12;

  logic          clk, rst, enc_a, enc_b, clear_pos;
  logic [PW-1:0] position;
  logic          dir;
  logic [SW-1:0] speed;
  logic          speed_valid, step_err;

  int n_cmp = 0;
  int n_bad = 0;
  int dut_err_cnt = 0;
  int g = 0;
  logic [1:0] gtab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_encoder_reader #(
    .POS_WIDTH(PW), .SPEED_WIDTH(SW), .WINDOW_CYCLES(W), .FILTER_LEN(F)
  ) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clear_pos(clear_pos),
    .position(position), .dir(dir), .speed(speed), .speed_valid(speed_valid),
    .step_err(step_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Keeps the raw per-edge samples of each channel. A channel's accepted level
  // becomes v once the F samples taken two or more edges ago (and since reset)
  // all equal v. Steps are classified by position difference on the Gray circle.
  bit qa[$];
  bit qb[$];
  int post;
  logic [1:0] mf, mp;
  logic [PW-1:0] m_pos;
  logic m_dir, m_err, m_sv;
  logic [SW-1:0] m_speed;
  int m_acc, m_since;

  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int settled(input bit q[$]);
    int s = q.size();
    bit v = q[s-1-F];
    for (int k = s - F; k <= s - 2; k++) if (q[k] != v) return -1;
    return int'(v);
  endfunction

  task automatic model_edge();
    int d, la, lb;
    bit stp;
    if (rst) begin
      mf = {qa[qa.size()-2], qb[qb.size()-2]};
      mp = mf;
      m_pos = '0; m_dir = 0; m_err = 0; m_sv = 0; m_speed = '0;
      m_acc = 0; m_since = 0; post = 0;
    end else begin
      d = (gidx(mf) - gidx(mp) + 4) % 4;
      stp = (d == 1) || (d == 3);
      m_since++;
      m_err = (d == 2);
      if (clear_pos) m_pos = '0;
      else if (d == 1) m_pos = m_pos + 1'b1;
      else if (d == 3) m_pos = m_pos - 1'b1;
      if (stp) m_dir = (d == 1);
      if (m_since % W == 0) begin
        m_speed = SW'(m_acc);
        m_sv = 1;
        m_acc = stp ? 1 : 0;
      end else begin
        m_sv = 0;
        if (stp && m_acc < (1 << SW) - 1) m_acc++;
      end
      mp = mf;
      if (post >= F) begin
        la = settled(qa);
        lb = settled(qb);
        if (la >= 0) mf[1] = la[0];
        if (lb >= 0) mf[0] = lb[0];
      end
    end
    qa.push_back(enc_a);
    qb.push_back(enc_b);
    post++;
    if (qa.size() > 32) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
  endtask

  always @(posedge clk) model_edge();

  // ---------------- helpers ----------------
  task automatic tick(input int k);
    repeat (k) begin
      @(negedge clk);
      if (step_err === 1'b1) dut_err_cnt++;
    end
  endtask

  task automatic drive_g(input int idx);
    g = idx % 4;
    {enc_a, enc_b} = gtab[g];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; enc_a = 0; enc_b = 0; clear_pos = 0; g = 0;
    tick(6);
    n_cmp++; if (position !== '0) begin n_bad++; $display("FAIL reset_position: got %h want 0000", position); end
    n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir: got %b want 0", dir); end
    n_cmp++; if (speed !== '0 || speed_valid !== 1'b0) begin n_bad++; $display("FAIL reset_speed: got %0d/%b want 0/0", speed, speed_valid); end
    n_cmp++; if (step_err !== 1'b0) begin n_bad++; $display("FAIL reset_step_err: got %b want 0", step_err); end
    rst = 0;
    tick(4);
    n_cmp++; if (position !== '0 || step_err !== 1'b0) begin n_bad++; $display("FAIL reset_exit: pos %h err %b want 0000 0", position, step_err); end
    $display("test_reset done: pos=%h dir=%b", position, dir);
  endtask

  task automatic test_forward();
    int e0 = dut_err_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_g(g + 1);
      tick(5);
      if (i < 2) begin
        n_cmp++; if (position !== PW'(i)) begin n_bad++; $display("FAIL latency_early step %0d: got %h want %h", i, position, PW'(i)); end
      end
      tick(1);
      if (i < 2) begin
        n_cmp++; if (position !== PW'(i + 1)) begin n_bad++; $display("FAIL latency_edge6 step %0d: got %h want %h", i, position, PW'(i + 1)); end
      end
      tick(4);
    end
    n_cmp++; if (position !== 16'd8) begin n_bad++; $display("FAIL fwd_position: got %h want 0008", position); end
    n_cmp++; if (dir !== 1'b1) begin n_bad++; $display("FAIL fwd_dir: got %b want 1", dir); end
    n_cmp++; if (dut_err_cnt !== e0) begin n_bad++; $display("FAIL fwd_no_err: got %0d pulses want 0", dut_err_cnt - e0); end
    n_cmp++; if (position !== m_pos) begin n_bad++; $display("FAIL fwd_model: got %h want %h", position, m_pos); end
    $display("test_forward done: pos=%h dir=%b", position, dir);
  endtask

  task automatic test_reverse_wrap();
    clear_pos = 1; tick(1); clear_pos = 0;
    for (int i = 0; i < 3; i++) begin
      drive_g(g + 3);
      tick(10);
    end
    n_cmp++; if (position !== 16'hFFFD) begin n_bad++; $display("FAIL rev_position: got %h want fffd", position); end
    n_cmp++; if (dir !== 1'b0) begin n_bad++; $display("FAIL rev_dir: got %b want 0", dir); end
    force dut.position_q = 16'h7FFF;
    m_pos = 16'h7FFF;
    tick(1);
    release dut.position_q;
    drive_g(g + 1);
    tick(10);
    n_cmp++; if (position !== 16'h8000) begin n_bad++; $display("FAIL wrap_7fff: got %h want 8000", position); end
    n_cmp++; if (position !== m_pos || dir !== m_dir) begin n_bad++; $display("FAIL wrap_model: got %h/%b want %h/%b", position, dir, m_pos, m_dir); end
    $display("test_reverse_wrap done: pos=%h dir=%b", position, dir);
  endtask

  task automatic test_glitch();
    int e0 = dut_err_cnt;
    // inputs are 11 here
    enc_a = 0; tick(2); enc_a = 1; tick(10);
    n_cmp++; if (position !== 16'h8000) begin n_bad++; $display("FAIL glitch_ignored: got %h want 8000", position); end
    n_cmp++; if (dut_err_cnt !== e0) begin n_bad++; $display("FAIL glitch_no_err: got %0d pulses want 0", dut_err_cnt - e0); end
    drive_g(1); tick(10);
    n_cmp++; if (position !== 16'h7FFF || dir !== 1'b0) begin n_bad++; $display("FAIL stable_change: got %h/%b want 7fff/0", position, dir); end
    $display("test_glitch done: pos=%h dir=%b", position, dir);
  endtask

  task automatic test_step_err();
    int e0 = dut_err_cnt;
    drive_g(g + 2);
    tick(12);
    n_cmp++; if (dut_err_cnt - e0 !== 1) begin n_bad++; $display("FAIL err_pulse_count: got %0d want 1", dut_err_cnt - e0); end
    n_cmp++; if (position !== 16'h7FFF || dir !== 1'b0) begin n_bad++; $display("FAIL err_hold: got %h/%b want 7fff/0", position, dir); end
    $display("test_step_err done: pulses=%0d pos=%h", dut_err_cnt - e0, position);
  endtask

  task automatic test_speed();
    int guard = 0;
    while (m_sv !== 1'b1 && guard < 3 * W) begin tick(1); guard++; end
    n_cmp++; if (guard >= 3 * W) begin n_bad++; $display("FAIL speed_align_timeout: waited %0d want < %0d", guard, 3 * W); end
    for (int i = 0; i < 25; i++) begin drive_g(g + 1); tick(3); end
    guard = 0;
    while (m_sv !== 1'b1 && guard < 2 * W) begin tick(1); guard++; end
    n_cmp++; if (speed_valid !== 1'b1 || speed !== 12'd25) begin n_bad++; $display("FAIL speed_window: got %0d/%b want 25/1", speed, speed_valid); end
    tick(1);
    n_cmp++; if (speed_valid !== 1'b0 || speed !== 12'd25) begin n_bad++; $display("FAIL speed_hold: got %0d/%b want 25/0", speed, speed_valid); end
    $display("test_speed window: speed=%0d", speed);
    // place a step so that it decodes on the wrap edge
    guard = 0;
    while (((m_since + 1) % W) != W - 5 && guard < 2 * W) begin tick(1); guard++; end
    drive_g(g + 1);
    tick(6);
    n_cmp++; if (speed_valid !== 1'b1 || speed !== 12'd0) begin n_bad++; $display("FAIL wrap_step_old_window: got %0d/%b want 0/1", speed, speed_valid); end
    n_cmp++; if (position !== m_pos) begin n_bad++; $display("FAIL wrap_step_pos: got %h want %h", position, m_pos); end
    tick(1);
    guard = 0;
    while (m_sv !== 1'b1 && guard < 2 * W) begin tick(1); guard++; end
    n_cmp++; if (speed_valid !== 1'b1 || speed !== 12'd1) begin n_bad++; $display("FAIL wrap_step_new_window: got %0d/%b want 1/1", speed, speed_valid); end
    $display("test_speed wrap: speed=%0d", speed);
  endtask

  task automatic test_random();
    for (int op = 0; op < 150; op++) begin
      int kind = $urandom_range(0, 9);
      int hold = $urandom_range(3, 8);
      int glen = 0;
      case (kind)
        0, 1, 2, 3: drive_g(g + 1);
        4, 5:       drive_g(g + 3);
        6:          drive_g(g + 2);
        7: begin
          glen = $urandom_range(1, 2);
          if ($urandom_range(0, 1) == 1) enc_a = ~enc_a; else enc_b = ~enc_b;
        end
        8:          clear_pos = 1;
        default:    ;
      endcase
      for (int ph = 0; ph < 2; ph++) begin
        int len = (ph == 0) ? ((glen > 0) ? glen : hold) : ((glen > 0) ? hold : 0);
        if (ph == 1 && glen > 0) {enc_a, enc_b} = gtab[g];
        for (int c = 0; c < len; c++) begin
          tick(1);
          clear_pos = 0;
          n_cmp++;
          if ({position, dir, step_err, speed, speed_valid} !== {m_pos, m_dir, m_err, m_speed, m_sv}) begin
            n_bad++;
            $display("FAIL random op %0d kind %0d: got pos=%h dir=%b err=%b spd=%0d sv=%b want pos=%h dir=%b err=%b spd=%0d sv=%b",
                     op, kind, position, dir, step_err, speed, speed_valid, m_pos, m_dir, m_err, m_speed, m_sv);
          end
        end
      end
    end
    $display("test_random done: pos=%h dir=%b speed=%0d", position, dir, speed);
  endtask

  task automatic test_clear_and_reset();
    int cnt = 0;
    drive_g(g + 1); tick(10);
    drive_g(g + 3); tick(5);
    clear_pos = 1; tick(1); clear_pos = 0;
    n_cmp++; if (position !== '0 || dir !== 1'b0) begin n_bad++; $display("FAIL clear_with_step: got %h/%b want 0000/0", position, dir); end
    tick(4);
    n_cmp++; if (position !== m_pos || dir !== m_dir) begin n_bad++; $display("FAIL clear_model: got %h/%b want %h/%b", position, dir, m_pos, m_dir); end
    tick(37);
    rst = 1; tick(1);
    n_cmp++;
    if (position !== '0 || dir !== 1'b0 || speed !== '0 || speed_valid !== 1'b0 || step_err !== 1'b0) begin
      n_bad++; $display("FAIL midwin_reset: got pos=%h dir=%b spd=%0d sv=%b err=%b want all 0", position, dir, speed, speed_valid, step_err);
    end
    rst = 0;
    while (speed_valid !== 1'b1 && cnt < 3 * W) begin tick(1); cnt++; end
    n_cmp++; if (cnt !== W) begin n_bad++; $display("FAIL first_speed_valid: got %0d cycles want %0d", cnt, W); end
    n_cmp++; if (speed !== '0) begin n_bad++; $display("FAIL first_speed_value: got %0d want 0", speed); end
    $display("test_clear_and_reset done: first speed_valid after %0d cycles", cnt);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin qa.push_back(1'b0); qb.push_back(1'b0); end
    post = 0; mf = 2'b00; mp = 2'b00; m_pos = '0; m_dir = 0; m_err = 0; m_sv = 0;
    m_speed = '0; m_acc = 0; m_since = 0;
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_glitch();
    test_step_err();
    test_speed();
    test_random();
    test_clear_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
